// File: rtl/bcd_to_bin_seq_if.sv
// Operand/result handshake bundle for bcd_to_bin_seq.
// Both channels use valid/ready: a beat transfers on a rising clk edge when valid && ready.
interface bcd_to_bin_seq_if #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 15
);
  logic                  in_valid;
  logic                  in_ready;
  logic [4*DIGITS-1:0]   bcd_in;
  logic                  carry_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [BIN_W-1:0]      bin_out;
  logic                  err;

  modport master (
    output in_valid, bcd_in, carry_in, out_ready,
    input  in_ready, out_valid, bin_out, err
  );

  modport slave (
    input  in_valid, bcd_in, carry_in, out_ready,
    output in_ready, out_valid, bin_out, err
  );
endinterface

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD(+carry)-to-binary converter, reverse double-dabble, one operand in flight.
// Optional macro BCD_CHECK_EN: reject digits >9 with err=1, bin_out=0. dbg_state: IDLE=0, SHIFT=1, DONE=2.
module bcd_to_bin_seq #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 15
) (
  input  logic              clk,
  input  logic              rst,
  bcd_to_bin_seq_if.slave   bus,
  output logic [1:0]        dbg_state
);
  localparam int BCD_W = 4 * (DIGITS + 1);
  localparam int REG_W = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

  state_t             state, state_nxt;
  logic [REG_W-1:0]   work_q, work_step;
  logic [CNT_W-1:0]   cnt_q;
  logic [BIN_W-1:0]   bin_q;
  logic               err_q;
  logic               bad_q;
  logic               bad_digit;
  logic               accept;
  logic               last_iter;

  assign accept    = bus.in_valid && (state == IDLE);
  assign last_iter = (cnt_q == CNT_W'(BIN_W - 1));

  // One iteration: shift right, then pull every digit (carry nibble too) back by 3 if >=8.
  always_comb begin
    work_step = work_q >> 1;
    for (int d = 0; d <= DIGITS; d++) begin
      if (work_step[BIN_W + 4*d +: 4] >= 4'd8)
        work_step[BIN_W + 4*d +: 4] = work_step[BIN_W + 4*d +: 4] - 4'd3;
    end
  end

  always_comb begin
    bad_digit = 1'b0;
`ifdef BCD_CHECK_EN
    for (int d = 0; d < DIGITS; d++) begin
      if (bus.bcd_in[4*d +: 4] > 4'd9) bad_digit = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SHIFT;
      SHIFT:   if (bad_q || last_iter) state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
    dbg_state     = state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work_q <= '0;
      cnt_q  <= '0;
      bin_q  <= '0;
      err_q  <= 1'b0;
      bad_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            work_q <= {3'b000, bus.carry_in, bus.bcd_in, {BIN_W{1'b0}}};
            cnt_q  <= '0;
            bad_q  <= bad_digit;
          end
        end
        SHIFT: begin
          work_q <= work_step;
          cnt_q  <= cnt_q + CNT_W'(1);
          // A rejected operand spends exactly one cycle here before reporting.
          if (bad_q) begin
            bin_q <= '0;
            err_q <= 1'b1;
          end else if (last_iter) begin
            bin_q <= work_step[BIN_W-1:0];
            err_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.bin_out = bin_q;
  assign bus.err     = err_q;
endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Directed bench for bcd_to_bin_seq: decimal-value model + scoreboard, plus literal result checks.
module tb_bcd_to_bin_seq;
  localparam int DIGITS = 4;
  localparam int BIN_W  = 15;
  localparam int LAT    = BIN_W;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_pass = 0;

  bcd_to_bin_seq_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();

  bcd_to_bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk(clk), .rst(rst), .bus(bus), .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // model: decimal value of the digits plus carry * 10^DIGITS
  function automatic int model_value(input logic [4*DIGITS-1:0] b, input logic c);
    logic [4*DIGITS-1:0] t;
    int v;
    t = b;
    v = 0;
    for (int d = DIGITS - 1; d >= 0; d--) v = v * 10 + int'(t[4*d +: 4]);
    return v + (c ? 10 ** DIGITS : 0);
  endfunction

  function automatic bit model_bad(input logic [4*DIGITS-1:0] b);
    logic [4*DIGITS-1:0] t;
    bit bad;
    t = b;
    bad = 1'b0;
`ifdef BCD_CHECK_EN
    for (int d = 0; d < DIGITS; d++) if (t[4*d +: 4] > 4'd9) bad = 1'b1;
`endif
    return bad;
  endfunction

  // scoreboard
  logic [BIN_W-1:0] exp_q[$];
  logic             exp_err_q[$];
  int               acc_q[$];
  int               lat_q[$];
  bit               busy = 1'b0;
  bit               prev_ov = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      exp_err_q.delete();
      acc_q.delete();
      lat_q.delete();
      busy    = 1'b0;
      prev_ov = 1'b0;
    end else begin
      check("in_ready_vs_busy", int'(bus.in_ready), int'(!busy));
      if (exp_q.size() == 0) begin
        check("out_valid_idle", int'(bus.out_valid), 0);
      end else if (bus.out_valid) begin
        if (!prev_ov) check("latency", cyc - acc_q[0], lat_q[0]);
        check("bin_out_model", int'(bus.bin_out), int'(exp_q[0]));
        check("err_model", int'(bus.err), int'(exp_err_q[0]));
        if (bus.out_ready) begin
          void'(exp_q.pop_front());
          void'(exp_err_q.pop_front());
          void'(acc_q.pop_front());
          void'(lat_q.pop_front());
          busy = 1'b0;
        end
      end
      prev_ov = bus.out_valid;
      if (bus.in_valid && bus.in_ready) begin
        if (model_bad(bus.bcd_in)) begin
          exp_q.push_back('0);
          exp_err_q.push_back(1'b1);
          lat_q.push_back(1);
        end else begin
          exp_q.push_back(BIN_W'(model_value(bus.bcd_in, bus.carry_in)));
          exp_err_q.push_back(1'b0);
          lat_q.push_back(LAT);
        end
        acc_q.push_back(cyc + 1);
        busy = 1'b1;
      end
    end
  end

  // driver tasks
  int acc_cyc;

  task automatic send(input logic [4*DIGITS-1:0] b, input logic c, input bit keep);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.bcd_in   = b;
    bus.carry_in = c;
    while (!bus.in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      check("accept_timeout", n, 0);
    end else begin
      @(posedge clk); #1;
      acc_cyc = cyc;
    end
    if (!keep) bus.in_valid = 1'b0;
  endtask

  task automatic wait_result(input string name, input int exp_val, input int exp_err, input int exp_lat);
    int n;
    n = 0;
    while (!bus.out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      check({name, "_timeout"}, n, 0);
    end else begin
      check({name, "_lat"}, cyc - acc_cyc, exp_lat);
      check({name, "_val"}, int'(bus.bin_out), exp_val);
      check({name, "_err"}, int'(bus.err), exp_err);
      if (bus.out_ready) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.bcd_in    = '0;
    bus.carry_in  = 1'b0;
    bus.out_ready = 1'b1;
    #12;
    check("rst_in_ready", int'(bus.in_ready), 1);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_bin_out", int'(bus.bin_out), 0);
    check("rst_err", int'(bus.err), 0);
    check("rst_state_idle", int'(dbg_state), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    send(16'h1234, 1'b0, 1'b0);
    wait_result("r1234", 'h04D2, 0, LAT);
    send(16'h9999, 1'b1, 1'b0);
    wait_result("r19999", 'h4E1F, 0, LAT);
    send(16'h0000, 1'b0, 1'b0);
    wait_result("r0", 0, 0, LAT);

    // back-to-back with in_valid held; bcd_in changes while the first one shifts
    send(16'h0500, 1'b0, 1'b1);
    bus.bcd_in = 16'h0042;
    wait_result("r500", 500, 0, LAT);
    check("turnaround_in_ready", int'(bus.in_ready), 1);
    send(16'h0042, 1'b0, 1'b0);
    wait_result("r42", 42, 0, LAT);

    // backpressure
    bus.out_ready = 1'b0;
    send(16'h0789, 1'b0, 1'b0);
    wait_result("r789", 789, 0, LAT);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("bp_out_valid", int'(bus.out_valid), 1);
      check("bp_bin_out", int'(bus.bin_out), 789);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_out_valid", int'(bus.out_valid), 0);
    check("bp_release_in_ready", int'(bus.in_ready), 1);
    check("bp_hold_bin_out", int'(bus.bin_out), 789);

    // reset at iteration 7
    send(16'h4321, 1'b0, 1'b0);
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_out_valid", int'(bus.out_valid), 0);
    check("midrst_bin_out", int'(bus.bin_out), 0);
    check("midrst_in_ready", int'(bus.in_ready), 1);
    @(posedge clk); #1;
    rst = 1'b0;
    send(16'h0001, 1'b0, 1'b0);
    wait_result("r1", 1, 0, LAT);

`ifdef BCD_CHECK_EN
    send(16'h12A4, 1'b0, 1'b0);
    wait_result("rbad", 0, 1, 1);
    send(16'h0010, 1'b0, 1'b0);
    wait_result("r10", 10, 0, LAT);
`endif

    repeat (3) @(posedge clk);
    #1;
    check("end_out_valid", int'(bus.out_valid), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
